tft_pattern_gen: RTL and testbench
==================================

Name: tft_pattern_gen

Overview:
Upstream pixel source for the TFT timing controller. Takes the active-area pixel coordinates (hcount/vcount) from the controller and returns RGB565 pixel data with zero latency.
- Four selectable test patterns: colour bars, grid, grey gradient, bouncing box.
- Mode selected by a debounced push-button.
- Mode changes and box motion are updated only at frame boundaries, so no tearing.

Parameters:
H_ACTIVE, 800, active pixels per line
V_ACTIVE, 480, active lines per frame
DEBOUNCE_CYCLES, 660000, stable-level cycles required to accept a key edge (20 ms at 33 MHz)
BOX_SIZE, 64, bouncing box edge length in pixels
BOX_STEP, 2, box displacement per frame per axis, in pixels

Ports:
clk33m  input  1  pixel clock, same clock as the timing controller
rst_n  input  1  asynchronous active-low reset
hcount  input  11  active-area column from controller; unsigned, wraps high outside the active area
vcount  input  11  active-area row from controller; same wrap behaviour
key_n  input  1  mode push-button, active-low, asynchronous to clk33m
data_out  output  16  RGB565 pixel, driven to the controller's data_in
mode  output  2  currently displayed pattern (for debug LEDs)
frame_tick  output  1  one-cycle pulse once per frame

Behaviour:
- Clock/reset: one clock, clk33m. Reset rst_n is asynchronous and active-low. All registers clear on reset:
  - mode=0, pending_mode=0, debounce counter=0, box_x=0, box_y=0, dir_x=+, dir_y=+, frame_tick=0.
- Key synchroniser:
  - key_n passes through a 2-FF synchroniser, reset value 1.
  - Debounce counter increments while the synced level differs from the accepted level. It resets to 0 when the levels match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the accepted level is updated.
  - An accepted 1->0 transition is a press.
  - A release glitch shorter than DEBOUNCE_CYCLES produces no event.
- Frame tick:
  - Registered; asserted for exactly one clk33m cycle when hcount==0 && vcount==V_ACTIVE.
  - This is the first blanking line after the active area, so exactly once per frame.
- Mode FSM, states MODE_BARS(0), MODE_GRID(1), MODE_GRAD(2), MODE_BOX(3):
  - A press sets pending_mode = pending_mode+1 (mod 4).
  - On frame_tick, mode <= pending_mode.
  - Multiple presses within one frame accumulate.
  - A press coinciding with frame_tick: the incremented value is applied at the next frame_tick.
- Box motion (box_x in 0..H_ACTIVE-BOX_SIZE, box_y in 0..V_ACTIVE-BOX_SIZE):
  - Updates on frame_tick in every mode, so the box keeps running while hidden.
  - Per axis: if the next position would exceed the upper limit, or go below 0, clamp to that limit and invert the direction. Otherwise add/subtract BOX_STEP.
  - Position arithmetic is 12-bit signed-safe; no wrap is permitted.
- Pixel path: combinational from hcount/vcount and registered state.
  - data_out=16'h0000 whenever hcount>=H_ACTIVE or vcount>=V_ACTIVE.
  - BARS: bar index = hcount/(H_ACTIVE/8). Colours in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - GRID: FFFF where hcount[4:0]==0 or vcount[4:0]==0, or on the last column/row; otherwise 0000.
  - GRAD: {hcount[9:5], hcount[9:4], hcount[9:5]}.
  - BOX: F800 when box_x<=hcount<box_x+BOX_SIZE and box_y<=vcount<box_y+BOX_SIZE; otherwise 001F.
- Reset mid-frame: outputs return to BARS immediately. Pixels for the rest of that frame follow the reset state.

Optional Feature:
TFT_PATTERN_AUTOCYCLE_EN
- Defined: adds an 8-bit frame counter, reset 0, incremented on frame_tick. When it wraps 255->0, pending_mode advances by 1, as if a press occurred. This increment is additive with any key press in the same cycle. A key press clears the counter to 0.
- Undefined: no counter is present, and mode changes only via key_n.

Test Plan:
1. Reset, key_n=1, mode BARS -> hcount=0/vcount=0 gives FFFF; hcount=150 gives FFE0; hcount=799 gives 0000; hcount=2047 (blanking wrap) gives 0000.
2. Hold key_n=0 for DEBOUNCE_CYCLES+10, then release -> mode stays 0 until frame_tick, then mode=1. In GRID, hcount=32/vcount=5 gives FFFF; hcount=33/vcount=5 gives 0000.
3. Key_n low pulse of DEBOUNCE_CYCLES/2 -> no mode change across 2 frames.
4. Two debounced presses within one frame starting in mode 0 -> mode=2 at next frame_tick. hcount=799 gives {5'd24, 6'd49, 5'd24}.
5. MODE_BOX, run 369 frames -> box_x=736 with dir_x reversed. The following frame gives box_x=734. box_y=416 reached at frame 208 and reverses.
6. Assert rst_n=0 for 3 cycles mid-line in MODE_BOX -> mode=0, box at (0,0), frame_tick=0 during reset. With AUTOCYCLE_EN defined and no presses, mode advances after 256 frames.

Source files
------------

// File: rtl/tft_pattern_gen.sv
// tft_pattern_gen: zero-latency RGB565 test-pattern source (bars, grid, gradient, bouncing box).
// Optional build macro TFT_PATTERN_AUTOCYCLE_EN advances the pattern every 256 frames.
module tft_pattern_gen #(
  parameter int H_ACTIVE        = 800,
  parameter int V_ACTIVE        = 480,
  parameter int DEBOUNCE_CYCLES = 660000,
  parameter int BOX_SIZE        = 64,
  parameter int BOX_STEP        = 2
) (
  input  logic        clk33m,
  input  logic        rst_n,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic        key_n,
  output logic [15:0] data_out,
  output logic [1:0]  mode,
  output logic        frame_tick
);

  localparam logic [1:0] MODE_BARS = 2'd0;
  localparam logic [1:0] MODE_GRID = 2'd1;
  localparam logic [1:0] MODE_GRAD = 2'd2;
  localparam logic [1:0] MODE_BOX  = 2'd3;

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [10:0]       H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0]       V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0]       BAR_W    = 11'(H_ACTIVE / 8);
  localparam logic [11:0]       BOX_W    = 12'(BOX_SIZE);
  localparam logic signed [11:0] X_MAX   = 12'(H_ACTIVE - BOX_SIZE);
  localparam logic signed [11:0] Y_MAX   = 12'(V_ACTIVE - BOX_SIZE);
  localparam logic signed [11:0] STEP    = 12'(BOX_STEP);

  logic             key_meta, key_sync, key_level;
  logic [CNT_W-1:0] deb_cnt;
  logic             press;
  logic [1:0]       pending_mode, mode_adv;
  logic [11:0]      box_x, box_y, next_x, next_y;
  logic             dir_x, dir_y, next_dir_x, next_dir_y;
  logic signed [11:0] step_x, step_y;
  logic             active, in_box;
  logic [10:0]      bar_idx;
  logic [11:0]      hx, vy;

  always_ff @(posedge clk33m or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
    end
  end

  // Accepted level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk33m or negedge rst_n) begin
    if (!rst_n) begin
      key_level <= 1'b1;
      deb_cnt   <= '0;
    end else if (key_sync == key_level) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      key_level <= key_sync;
      deb_cnt   <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign press = key_level && !key_sync && (deb_cnt == DEB_LAST);

  always_ff @(posedge clk33m or negedge rst_n) begin
    if (!rst_n) frame_tick <= 1'b0;
    else        frame_tick <= (hcount == 11'd0) && (vcount == V_ACT);
  end

`ifdef TFT_PATTERN_AUTOCYCLE_EN
  logic [7:0] frame_cnt;
  logic       cnt_wrap;

  assign cnt_wrap = frame_tick && (frame_cnt == 8'hFF);

  always_ff @(posedge clk33m or negedge rst_n) begin
    if (!rst_n)          frame_cnt <= 8'd0;
    else if (press)      frame_cnt <= 8'd0;
    else if (frame_tick) frame_cnt <= frame_cnt + 8'd1;
  end

  assign mode_adv = {1'b0, press} + {1'b0, cnt_wrap};
`else
  assign mode_adv = {1'b0, press};
`endif

  // A press landing on frame_tick is seen by mode only at the following tick.
  always_ff @(posedge clk33m or negedge rst_n) begin
    if (!rst_n) begin
      pending_mode <= MODE_BARS;
      mode         <= MODE_BARS;
    end else begin
      pending_mode <= pending_mode + mode_adv;
      if (frame_tick) mode <= pending_mode;
    end
  end

  always_comb begin
    step_x = dir_x ? ($signed(box_x) + STEP) : ($signed(box_x) - STEP);
    step_y = dir_y ? ($signed(box_y) + STEP) : ($signed(box_y) - STEP);
    next_x = $unsigned(step_x);
    next_y = $unsigned(step_y);
    next_dir_x = dir_x;
    next_dir_y = dir_y;
    if (step_x > X_MAX) begin
      next_x = X_MAX;
      next_dir_x = ~dir_x;
    end else if (step_x < 12'sd0) begin
      next_x = 12'd0;
      next_dir_x = ~dir_x;
    end
    if (step_y > Y_MAX) begin
      next_y = Y_MAX;
      next_dir_y = ~dir_y;
    end else if (step_y < 12'sd0) begin
      next_y = 12'd0;
      next_dir_y = ~dir_y;
    end
  end

  always_ff @(posedge clk33m or negedge rst_n) begin
    if (!rst_n) begin
      box_x <= 12'd0;
      box_y <= 12'd0;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
    end else if (frame_tick) begin
      box_x <= next_x;
      box_y <= next_y;
      dir_x <= next_dir_x;
      dir_y <= next_dir_y;
    end
  end

  assign active  = (hcount < H_ACT) && (vcount < V_ACT);
  assign bar_idx = hcount / BAR_W;
  assign hx      = {1'b0, hcount};
  assign vy      = {1'b0, vcount};
  assign in_box  = (hx >= box_x) && (hx < box_x + BOX_W) &&
                   (vy >= box_y) && (vy < box_y + BOX_W);

  always_comb begin
    data_out = 16'h0000;
    if (active) begin
      case (mode)
        MODE_BARS: begin
          case (bar_idx)
            11'd0:   data_out = 16'hFFFF;
            11'd1:   data_out = 16'hFFE0;
            11'd2:   data_out = 16'h07FF;
            11'd3:   data_out = 16'h07E0;
            11'd4:   data_out = 16'hF81F;
            11'd5:   data_out = 16'hF800;
            11'd6:   data_out = 16'h001F;
            default: data_out = 16'h0000;
          endcase
        end
        MODE_GRID: begin
          if ((hcount[4:0] == 5'd0) || (vcount[4:0] == 5'd0) ||
              (hcount == H_ACT - 11'd1) || (vcount == V_ACT - 11'd1))
            data_out = 16'hFFFF;
        end
        MODE_GRAD: data_out = {hcount[9:5], hcount[9:4], hcount[9:5]};
        default:   data_out = in_box ? 16'hF800 : 16'h001F;
      endcase
    end
  end

endmodule

// File: tb/tb_tft_pattern_gen.sv
// Self-checking bench for tft_pattern_gen: pixel scoreboard, key debounce, mode changes, box bounce.
module tb_tft_pattern_gen;

  localparam int DEB = 20;

  logic        clk33m = 1'b0;
  logic        rst_n  = 1'b0;
  logic [10:0] hcount = 11'd100;
  logic [10:0] vcount = 11'd100;
  logic        key_n  = 1'b1;
  logic [15:0] data_out;
  logic [1:0]  mode;
  logic        frame_tick;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [15:0] exp_q[$];
  logic [1:0]  mode_exp = 2'd0;
  logic [1:0]  pend_exp = 2'd0;
  int          frames   = 0;
`ifdef TFT_PATTERN_AUTOCYCLE_EN
  int          ac_cnt   = 0;
`endif

  tft_pattern_gen #(
    .H_ACTIVE(800), .V_ACTIVE(480), .DEBOUNCE_CYCLES(DEB), .BOX_SIZE(64), .BOX_STEP(2)
  ) dut (
    .clk33m(clk33m), .rst_n(rst_n), .hcount(hcount), .vcount(vcount), .key_n(key_n),
    .data_out(data_out), .mode(mode), .frame_tick(frame_tick)
  );

  // clock / reset
  always #15 clk33m = ~clk33m;

  task automatic apply_reset();
    @(posedge clk33m); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk33m);
    #1 rst_n = 1'b1;
    mode_exp = 2'd0;
    pend_exp = 2'd0;
    frames   = 0;
`ifdef TFT_PATTERN_AUTOCYCLE_EN
    ac_cnt   = 0;
`endif
  endtask

  // drivers
  task automatic drive_pixel(input logic [10:0] h, input logic [10:0] v, input logic [15:0] e);
    @(posedge clk33m); #1;
    hcount = h;
    vcount = v;
    exp_q.push_back(e);
  endtask

  task automatic model_frame();
    mode_exp = pend_exp;
`ifdef TFT_PATTERN_AUTOCYCLE_EN
    if (ac_cnt == 255) pend_exp = pend_exp + 2'd1;
    ac_cnt = (ac_cnt + 1) % 256;
`endif
    frames++;
  endtask

  task automatic do_frame();
    @(posedge clk33m); #1;
    hcount = 11'd0;
    vcount = 11'd480;
    @(posedge clk33m); #1;
    hcount = 11'd1;
    @(posedge clk33m); #1;
    hcount = 11'd100;
    vcount = 11'd100;
    model_frame();
  endtask

  task automatic press_key();
    @(posedge clk33m); #1 key_n = 1'b0;
    repeat (DEB + 10) @(posedge clk33m);
    #1 key_n = 1'b1;
    repeat (DEB + 10) @(posedge clk33m);
    pend_exp = pend_exp + 2'd1;
`ifdef TFT_PATTERN_AUTOCYCLE_EN
    ac_cnt = 0;
`endif
  endtask

  task automatic test_reset();
    logic [10:0] hs[8] = '{11'd0, 11'd150, 11'd799, 11'd2047, 11'd300, 11'd450, 11'd0, 11'd10};
    logic [10:0] vs[8] = '{11'd0, 11'd0, 11'd0, 11'd0, 11'd100, 11'd20, 11'd479, 11'd2047};
    logic [15:0] es[8] = '{16'hFFFF, 16'hFFE0, 16'h0000, 16'h0000, 16'h07E0, 16'hF81F, 16'hFFFF, 16'h0000};
    logic [15:0] e;
    repeat (3) @(posedge clk33m);
    @(negedge clk33m);
    tests_run++;
    if (mode !== 2'd0 || frame_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: mode=%0d frame_tick=%b, expected mode=0 frame_tick=0", mode, frame_tick);
    end
    @(posedge clk33m); #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_pixel(hs[i], vs[i], es[i]);
      @(negedge clk33m);
      e = exp_q.pop_front();
      tests_run++;
      if (data_out !== e) begin
        tests_failed++;
        $display("FAIL bars_px(%0d,%0d): got %h, expected %h", hs[i], vs[i], data_out, e);
      end
    end
  endtask

  task automatic test_frame_tick();
    logic [2:0] got;
    @(posedge clk33m); #1;
    hcount = 11'd0;
    vcount = 11'd480;
    @(negedge clk33m) got[2] = frame_tick;
    @(posedge clk33m); #1 hcount = 11'd1;
    @(negedge clk33m) got[1] = frame_tick;
    @(posedge clk33m); #1;
    hcount = 11'd100;
    vcount = 11'd100;
    @(negedge clk33m) got[0] = frame_tick;
    model_frame();
    tests_run++;
    if (got !== 3'b010) begin
      tests_failed++;
      $display("FAIL frame_tick_pulse: sampled %b, expected 010", got);
    end
  endtask

  task automatic test_press();
    logic [10:0] hs[4] = '{11'd32, 11'd33, 11'd799, 11'd33};
    logic [10:0] vs[4] = '{11'd5, 11'd5, 11'd5, 11'd479};
    logic [15:0] es[4] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF};
    logic [15:0] e;
    press_key();
    @(negedge clk33m);
    tests_run++;
    if (mode !== 2'd0) begin
      tests_failed++;
      $display("FAIL press_before_tick: mode=%0d, expected 0", mode);
    end
    do_frame();
    @(negedge clk33m);
    tests_run++;
    if (mode !== mode_exp) begin
      tests_failed++;
      $display("FAIL press_after_tick: mode=%0d, expected %0d", mode, mode_exp);
    end
    for (int i = 0; i < 4; i++) begin
      drive_pixel(hs[i], vs[i], es[i]);
      @(negedge clk33m);
      e = exp_q.pop_front();
      tests_run++;
      if (data_out !== e) begin
        tests_failed++;
        $display("FAIL grid_px(%0d,%0d): got %h, expected %h", hs[i], vs[i], data_out, e);
      end
    end
  endtask

  task automatic test_glitch();
    @(posedge clk33m); #1 key_n = 1'b0;
    repeat (DEB / 2) @(posedge clk33m);
    #1 key_n = 1'b1;
    repeat (DEB + 10) @(posedge clk33m);
    for (int f = 0; f < 2; f++) begin
      do_frame();
      @(negedge clk33m);
      tests_run++;
      if (mode !== mode_exp) begin
        tests_failed++;
        $display("FAIL glitch_frame%0d: mode=%0d, expected %0d", f, mode, mode_exp);
      end
    end
  endtask

  task automatic test_two_presses();
    logic [10:0] hs[3] = '{11'd799, 11'd0, 11'd32};
    logic [15:0] es[3] = '{16'hC638, 16'h0000, 16'h0841};
    logic [15:0] e;
    apply_reset();
    press_key();
    press_key();
    do_frame();
    @(negedge clk33m);
    tests_run++;
    if (mode !== mode_exp) begin
      tests_failed++;
      $display("FAIL two_presses_mode: mode=%0d, expected %0d", mode, mode_exp);
    end
    for (int i = 0; i < 3; i++) begin
      drive_pixel(hs[i], 11'd7, es[i]);
      @(negedge clk33m);
      e = exp_q.pop_front();
      tests_run++;
      if (data_out !== e) begin
        tests_failed++;
        $display("FAIL grad_px(%0d,7): got %h, expected %h", hs[i], data_out, e);
      end
    end
  endtask

  task automatic test_box();
    int cp_f[5] = '{208, 209, 210, 369, 370};
    int cp_x[5] = '{416, 418, 420, 736, 734};
    int cp_y[5] = '{416, 416, 414, 96, 94};
    int px[6], py[6];
    logic [15:0] pe[6];
    logic [15:0] e;
    press_key();
    do_frame();
    for (int k = 0; k < 5; k++) begin
      while (frames < cp_f[k]) do_frame();
      @(negedge clk33m);
      tests_run++;
      if (mode !== mode_exp) begin
        tests_failed++;
        $display("FAIL box_mode_f%0d: mode=%0d, expected %0d", cp_f[k], mode, mode_exp);
      end
      if (mode_exp == 2'd3) begin
        px[0] = cp_x[k];      py[0] = cp_y[k];      pe[0] = 16'hF800;
        px[1] = cp_x[k] + 63; py[1] = cp_y[k] + 63; pe[1] = 16'hF800;
        px[2] = cp_x[k] + 64; py[2] = cp_y[k];      pe[2] = (px[2] >= 800) ? 16'h0000 : 16'h001F;
        px[3] = cp_x[k] - 1;  py[3] = cp_y[k];      pe[3] = 16'h001F;
        px[4] = cp_x[k];      py[4] = cp_y[k] - 1;  pe[4] = 16'h001F;
        px[5] = cp_x[k];      py[5] = cp_y[k] + 64; pe[5] = (py[5] >= 480) ? 16'h0000 : 16'h001F;
        for (int i = 0; i < 6; i++) begin
          drive_pixel(11'(px[i]), 11'(py[i]), pe[i]);
          @(negedge clk33m);
          e = exp_q.pop_front();
          tests_run++;
          if (data_out !== e) begin
            tests_failed++;
            $display("FAIL box_px_f%0d(%0d,%0d): got %h, expected %h", cp_f[k], px[i], py[i], data_out, e);
          end
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [10:0] hs[4] = '{11'd2, 11'd1, 11'd65, 11'd66};
    logic [15:0] es[4] = '{16'hF800, 16'h001F, 16'hF800, 16'h001F};
    logic [15:0] e;
    @(posedge clk33m); #1;
    hcount = 11'd100;
    vcount = 11'd50;
    rst_n  = 1'b0;
    @(negedge clk33m);
    tests_run++;
    if (mode !== 2'd0 || data_out !== 16'hFFE0) begin
      tests_failed++;
      $display("FAIL mid_reset_out: mode=%0d data=%h, expected mode=0 data=ffe0", mode, data_out);
    end
    @(posedge clk33m); #1;
    hcount = 11'd0;
    vcount = 11'd480;
    @(posedge clk33m); #1;
    hcount = 11'd100;
    vcount = 11'd50;
    @(negedge clk33m);
    tests_run++;
    if (frame_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_tick: frame_tick=%b, expected 0", frame_tick);
    end
    @(posedge clk33m); #1 rst_n = 1'b1;
    mode_exp = 2'd0;
    pend_exp = 2'd0;
    frames   = 0;
`ifdef TFT_PATTERN_AUTOCYCLE_EN
    ac_cnt   = 0;
`endif
    repeat (3) press_key();
    do_frame();
    @(negedge clk33m);
    tests_run++;
    if (mode !== mode_exp) begin
      tests_failed++;
      $display("FAIL mid_reset_mode: mode=%0d, expected %0d", mode, mode_exp);
    end
    for (int i = 0; i < 4; i++) begin
      drive_pixel(hs[i], (i == 2) ? 11'd65 : 11'd2, es[i]);
      @(negedge clk33m);
      e = exp_q.pop_front();
      tests_run++;
      if (data_out !== e) begin
        tests_failed++;
        $display("FAIL mid_reset_box_px(%0d): got %h, expected %h", hs[i], data_out, e);
      end
    end
  endtask

  task automatic test_autocycle();
    apply_reset();
    repeat (256) do_frame();
    @(negedge clk33m);
    tests_run++;
    if (mode !== 2'd0) begin
      tests_failed++;
      $display("FAIL autocycle_256: mode=%0d, expected 0", mode);
    end
    do_frame();
    @(negedge clk33m);
    tests_run++;
`ifdef TFT_PATTERN_AUTOCYCLE_EN
    if (mode !== 2'd1) begin
      tests_failed++;
      $display("FAIL autocycle_257: mode=%0d, expected 1", mode);
    end
`else
    if (mode !== 2'd0) begin
      tests_failed++;
      $display("FAIL no_autocycle_257: mode=%0d, expected 0", mode);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_frame_tick();
    test_press();
    test_glitch();
    test_two_presses();
    test_box();
    test_mid_reset();
    test_autocycle();
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
